// File: rtl/bytecode_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : bytecode_sequencer
// Purpose  : Translates a small subset of Java bytecode, read from a 1-cycle
//            latency ROM, into a stream of ARM words over valid/ready.
// Revision : 1.0  initial release
// ============================================================================
module bytecode_sequencer #(
  parameter int ADDR_WIDTH = 6,
  parameter int START_ADDR = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [7:0]            rom_data,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic [31:0]           instr_data,
  output logic                  busy,
  output logic                  done,
  output logic                  err_unknown
);

  localparam logic [ADDR_WIDTH-1:0] c_LAST_ADDR  = '1;
  localparam logic [ADDR_WIDTH-1:0] c_START_ADDR = ADDR_WIDTH'(START_ADDR);
  localparam logic [7:0]            c_OP_BIPUSH  = 8'h10;
  localparam logic [7:0]            c_OP_RETURN  = 8'hB1;
  localparam logic [7:0]            c_OP_IADD    = 8'h60;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_DECODE  = 3'd2,
    S_OPERAND = 3'd3,
    S_EMIT    = 3'd4,
    S_FINISH  = 3'd5
  } state_t;

  state_t                  r_state;
  state_t                  w_next;
  logic [ADDR_WIDTH-1:0]   r_rom_addr;
  logic [7:0]              r_opcode;
  logic [7:0]              r_operand;
  logic [1:0]              r_widx;
  logic                    r_err;
  logic                    r_last;
  logic                    r_need_op;
  logic                    w_at_last;
  logic                    w_last_word;
  logic [1:0]              w_dec_count;
  logic [31:0]             w_word;

  // Number of ARM words an opcode expands to; zero marks unsupported opcodes.
  function automatic logic [1:0] f_count(input logic [7:0] op);
    logic [1:0] n;
    n = 2'd0;
    if (op >= 8'h03 && op <= 8'h08) n = 2'd2;
    if (op == c_OP_BIPUSH)          n = 2'd2;
    if (op >= 8'h1A && op <= 8'h1D) n = 2'd2;
    if (op >= 8'h3B && op <= 8'h3E) n = 2'd2;
    if (op == c_OP_IADD)            n = 2'd3;
    return n;
  endfunction

  function automatic logic [31:0] f_word(input logic [7:0] op, input logic [7:0] b,
                                         input logic [1:0] idx);
    logic [31:0] w;
    w = 32'h0;
    if (op >= 8'h03 && op <= 8'h08)
      w = (idx == 2'd0) ? (32'hE3A01000 | {24'h0, op - 8'h03}) : 32'hE92D0002;
    else if (op == c_OP_BIPUSH)
      w = (idx == 2'd0) ? (32'hE3A01000 | {24'h0, b}) : 32'hE92D0002;
    else if (op >= 8'h1A && op <= 8'h1D)
      w = (idx == 2'd0) ? (32'hE5931000 | {24'h0, op - 8'h1A}) : 32'hE92D0002;
    else if (op >= 8'h3B && op <= 8'h3E)
      w = (idx == 2'd0) ? 32'hE8BD0002 : (32'hE5831000 | {24'h0, op - 8'h3B});
    else if (op == c_OP_IADD) begin
      case (idx)
        2'd0:    w = 32'hE8BD0006;
        2'd1:    w = 32'hE0811002;
        default: w = 32'hE92D0002;
      endcase
    end
    return w;
  endfunction

  assign w_at_last   = (r_rom_addr == c_LAST_ADDR);
  assign w_dec_count = f_count(rom_data);
  assign w_last_word = (r_widx == (f_count(r_opcode) - 2'd1));
  assign w_word      = f_word(r_opcode, r_operand, r_widx);

  // All outputs come from registers only, so valid never follows ready combinationally.
  assign rom_addr    = r_rom_addr;
  assign instr_valid = (r_state == S_EMIT);
  assign instr_data  = (r_state == S_EMIT) ? w_word : 32'h0;
  assign busy        = (r_state != S_IDLE);
  assign done        = (r_state == S_FINISH);
  assign err_unknown = r_err;

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (start) w_next = S_FETCH;
      S_FETCH:   w_next = r_need_op ? S_OPERAND : S_DECODE;
      S_DECODE: begin
        if (rom_data == c_OP_RETURN)      w_next = S_FINISH;
        else if (rom_data == c_OP_BIPUSH) w_next = w_at_last ? S_FINISH : S_FETCH;
        else if (w_dec_count != 2'd0)     w_next = S_EMIT;
        else                              w_next = w_at_last ? S_FINISH : S_FETCH;
      end
      S_OPERAND: w_next = S_EMIT;
      S_EMIT:    if (instr_ready && w_last_word) w_next = r_last ? S_FINISH : S_FETCH;
      S_FINISH:  w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  // Address is held at the top of the program space rather than wrapping to 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rom_addr <= '0;
      r_opcode   <= 8'h0;
      r_operand  <= 8'h0;
      r_widx     <= 2'd0;
      r_err      <= 1'b0;
      r_last     <= 1'b0;
      r_need_op  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_rom_addr <= c_START_ADDR;
            r_err      <= 1'b0;
            r_last     <= 1'b0;
            r_need_op  <= 1'b0;
            r_widx     <= 2'd0;
          end
        end
        S_DECODE: begin
          r_opcode <= rom_data;
          r_widx   <= 2'd0;
          r_last   <= w_at_last;
          if (!w_at_last) r_rom_addr <= r_rom_addr + 1'b1;
          if (rom_data == c_OP_BIPUSH) begin
            if (w_at_last) r_err     <= 1'b1;
            else           r_need_op <= 1'b1;
          end else if (rom_data != c_OP_RETURN && w_dec_count == 2'd0) begin
            r_err <= 1'b1;
          end
        end
        S_OPERAND: begin
          r_operand <= rom_data;
          r_need_op <= 1'b0;
          r_last    <= w_at_last;
          if (!w_at_last) r_rom_addr <= r_rom_addr + 1'b1;
        end
        S_EMIT: begin
          if (instr_ready) r_widx <= w_last_word ? 2'd0 : r_widx + 2'd1;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bytecode_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_bytecode_sequencer
// Purpose  : Scoreboard bench: expected ARM words queued per program, compared
//            against words observed on accepted handshakes.
// Revision : 1.0  initial release
// ============================================================================
module tb_bytecode_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [5:0]  rom_addr;
  logic [7:0]  rom_data = 8'h0;
  logic        instr_valid;
  logic        instr_ready = 1'b1;
  logic [31:0] instr_data;
  logic        busy;
  logic        done;
  logic        err_unknown;

  logic [7:0]  rom [64];
  logic [31:0] exp_q[$];
  logic [31:0] obs_q[$];
  logic [5:0]  addr_q[$];
  int          checks = 0;
  int          errors = 0;
  int          done_cnt = 0;
  int          busy_cycles = 0;
  int          stall_bad = 0;
  logic        have_prev = 1'b0;
  logic [31:0] prev_data = 32'h0;

  bytecode_sequencer #(.ADDR_WIDTH(6), .START_ADDR(0)) dut (
    .clk(clk), .reset(reset), .start(start), .rom_addr(rom_addr), .rom_data(rom_data),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_data(instr_data),
    .busy(busy), .done(done), .err_unknown(err_unknown)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rom_data <= rom[rom_addr];

  // Observation only: accepted words, done pulses, busy length, address trace, hold stability.
  always @(negedge clk) begin
    if (reset) begin
      have_prev = 1'b0;
    end else begin
      if (instr_valid && instr_ready) obs_q.push_back(instr_data);
      if (done) done_cnt++;
      if (busy) busy_cycles++;
      if (busy && (addr_q.size() == 0 || addr_q[$] !== rom_addr)) addr_q.push_back(rom_addr);
      if (have_prev && (!instr_valid || instr_data !== prev_data)) stall_bad++;
      have_prev = instr_valid && !instr_ready;
      prev_data = instr_data;
    end
  end

  task automatic load_rom(input logic [7:0] b0, input logic [7:0] b1,
                          input logic [7:0] b2, input logic [7:0] b3);
    for (int i = 0; i < 64; i++) rom[i] = 8'hB1;
    rom[0] = b0; rom[1] = b1; rom[2] = b2; rom[3] = b3;
  endtask

  task automatic clear_obs();
    exp_q.delete(); obs_q.delete(); addr_q.delete();
    busy_cycles = 0; stall_bad = 0;
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic run_until_done(input int budget, input bit toggle, output bit ok);
    int base;
    base = done_cnt;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (toggle) instr_ready = ~instr_ready;
      if (done_cnt != base) begin ok = 1'b1; break; end
    end
    instr_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (rom_addr !== 6'd0) begin errors++; $display("FAIL reset_addr got %0h want 0", rom_addr); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", instr_valid); end
    checks++; if (instr_data !== 32'h0) begin errors++; $display("FAIL reset_data got %h want 0", instr_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (err_unknown !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", err_unknown); end
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_const_store();
    bit ok;
    int d0;
    logic [31:0] e, o;
    load_rom(8'h04, 8'h3C, 8'hB1, 8'hB1);
    clear_obs();
    exp_q.push_back(32'hE3A01001); exp_q.push_back(32'hE92D0002);
    exp_q.push_back(32'hE8BD0002); exp_q.push_back(32'hE5831001);
    d0 = done_cnt;
    pulse_start();
    run_until_done(100, 1'b0, ok);
    checks++; if (!ok) begin errors++; $display("FAIL const_timeout got no done want done"); end
    checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL const_count got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++; if (o !== e) begin errors++; $display("FAIL const_word got %h want %h", o, e); end
    end
    checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL const_done got %0d want 1", done_cnt - d0); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL const_busy got %b want 0", busy); end
    checks++; if (busy_cycles != 11) begin errors++; $display("FAIL const_cycles got %0d want 11", busy_cycles); end
    checks++; if (err_unknown !== 1'b0) begin errors++; $display("FAIL const_err got %b want 0", err_unknown); end
  endtask

  task automatic test_bipush();
    bit ok;
    logic [31:0] e, o;
    load_rom(8'h10, 8'h2A, 8'hB1, 8'hB1);
    clear_obs();
    exp_q.push_back(32'hE3A0102A); exp_q.push_back(32'hE92D0002);
    pulse_start();
    run_until_done(100, 1'b0, ok);
    checks++; if (!ok) begin errors++; $display("FAIL bipush_timeout got no done want done"); end
    checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL bipush_count got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++; if (o !== e) begin errors++; $display("FAIL bipush_word got %h want %h", o, e); end
    end
    checks++;
    if (addr_q.size() < 3 || addr_q[0] !== 6'd0 || addr_q[1] !== 6'd1 || addr_q[2] !== 6'd2) begin
      errors++; $display("FAIL bipush_addr got size %0d first %0h want 0,1,2", addr_q.size(),
                         (addr_q.size() > 0) ? addr_q[0] : 6'h3F);
    end
    checks++; if (busy_cycles != 9) begin errors++; $display("FAIL bipush_cycles got %0d want 9", busy_cycles); end
  endtask

  task automatic test_backpressure();
    bit ok;
    logic [31:0] e, o;
    load_rom(8'h1B, 8'h1C, 8'h60, 8'hB1);
    clear_obs();
    exp_q.push_back(32'hE5931001); exp_q.push_back(32'hE92D0002);
    exp_q.push_back(32'hE5931002); exp_q.push_back(32'hE92D0002);
    exp_q.push_back(32'hE8BD0006); exp_q.push_back(32'hE0811002);
    exp_q.push_back(32'hE92D0002);
    instr_ready = 1'b1;
    pulse_start();
    run_until_done(200, 1'b1, ok);
    checks++; if (!ok) begin errors++; $display("FAIL bp_timeout got no done want done"); end
    checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL bp_count got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++; if (o !== e) begin errors++; $display("FAIL bp_word got %h want %h", o, e); end
    end
    checks++; if (stall_bad != 0) begin errors++; $display("FAIL bp_stable got %0d violations want 0", stall_bad); end
  endtask

  task automatic test_unknown();
    bit ok;
    logic [31:0] e, o;
    load_rom(8'hFF, 8'h03, 8'hB1, 8'hB1);
    clear_obs();
    exp_q.push_back(32'hE3A01000); exp_q.push_back(32'hE92D0002);
    pulse_start();
    @(posedge clk); @(posedge clk); #1;
    checks++; if (err_unknown !== 1'b1) begin errors++; $display("FAIL unk_err_early got %b want 1", err_unknown); end
    run_until_done(100, 1'b0, ok);
    checks++; if (!ok) begin errors++; $display("FAIL unk_timeout got no done want done"); end
    checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL unk_count got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++; if (o !== e) begin errors++; $display("FAIL unk_word got %h want %h", o, e); end
    end
    checks++; if (err_unknown !== 1'b1) begin errors++; $display("FAIL unk_err_sticky got %b want 1", err_unknown); end
  endtask

  task automatic test_reset_mid_emit();
    bit ok;
    bit seen;
    logic [31:0] e, o;
    load_rom(8'h60, 8'hB1, 8'hB1, 8'hB1);
    clear_obs();
    instr_ready = 1'b0;
    pulse_start();
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (instr_valid) begin seen = 1'b1; break; end
      @(posedge clk); #1;
    end
    checks++; if (!seen) begin errors++; $display("FAIL rst_mid_wait got no valid want valid"); end
    checks++; if (err_unknown !== 1'b0) begin errors++; $display("FAIL rst_mid_errclr got %b want 0", err_unknown); end
    instr_ready = 1'b1;
    @(posedge clk); #1;
    instr_ready = 1'b0;
    checks++; if (instr_data !== 32'hE0811002 || instr_valid !== 1'b1) begin
      errors++; $display("FAIL rst_mid_word2 got %h/%b want e0811002/1", instr_data, instr_valid);
    end
    reset = 1'b1;
    @(posedge clk); #1;
    checks++; if (instr_valid !== 1'b0 || instr_data !== 32'h0) begin
      errors++; $display("FAIL rst_mid_drop got %b/%h want 0/0", instr_valid, instr_data);
    end
    checks++; if (busy !== 1'b0 || done !== 1'b0 || rom_addr !== 6'd0) begin
      errors++; $display("FAIL rst_mid_outs got busy %b done %b addr %0h want 0 0 0", busy, done, rom_addr);
    end
    reset = 1'b0;
    instr_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    checks++; if (instr_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL rst_mid_quiet got valid %b busy %b want 0 0", instr_valid, busy);
    end
    checks++; if (obs_q.size() != 1 || obs_q[0] !== 32'hE8BD0006) begin
      errors++; $display("FAIL rst_mid_accepted got %0d words want 1", obs_q.size());
    end
    load_rom(8'h03, 8'hB1, 8'hB1, 8'hB1);
    clear_obs();
    exp_q.push_back(32'hE3A01000); exp_q.push_back(32'hE92D0002);
    pulse_start();
    run_until_done(100, 1'b0, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rst_restart_timeout got no done want done"); end
    checks++; if (addr_q.size() == 0 || addr_q[0] !== 6'd0) begin errors++; $display("FAIL rst_restart_addr got bad start want 0"); end
    checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL rst_restart_count got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++; if (o !== e) begin errors++; $display("FAIL rst_restart_word got %h want %h", o, e); end
    end
  endtask

  task automatic test_fill_wrap();
    bit ok;
    int d0;
    int bad;
    logic [31:0] e, o;
    for (int i = 0; i < 64; i++) rom[i] = 8'h03;
    clear_obs();
    for (int i = 0; i < 64; i++) begin
      exp_q.push_back(32'hE3A01000); exp_q.push_back(32'hE92D0002);
    end
    d0 = done_cnt;
    pulse_start();
    repeat (20) @(posedge clk);
    pulse_start();
    run_until_done(1000, 1'b0, ok);
    repeat (5) @(posedge clk);
    #1;
    checks++; if (!ok) begin errors++; $display("FAIL fill_timeout got no done want done"); end
    checks++; if (obs_q.size() != 128) begin errors++; $display("FAIL fill_count got %0d want 128", obs_q.size()); end
    bad = 0;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      if (o !== e) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL fill_words got %0d wrong want 0", bad); end
    checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL fill_done got %0d want 1", done_cnt - d0); end
    checks++; if (busy_cycles != 257) begin errors++; $display("FAIL fill_cycles got %0d want 257", busy_cycles); end
    checks++; if (busy !== 1'b0 || err_unknown !== 1'b0) begin
      errors++; $display("FAIL fill_final got busy %b err %b want 0 0", busy, err_unknown);
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) rom[i] = 8'hB1;
    test_reset();
    test_const_store();
    test_bipush();
    test_backpressure();
    test_unknown();
    test_reset_mid_emit();
    test_fill_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
